alu8_cmd_issuer: RTL and testbench
==================================

ALU8_CMD_ISSUER -- requirements
Module: alu8_cmd_issuer

Interface
- REQ-001: Parameter TIMEOUT_CYCLES, default 255, Done_i wait limit in clk cycles (range 1..65535).
- REQ-002: clk  input  1  single clock; all logic rising-edge.
- REQ-003: reset  input  1  synchronous, active-high.
- REQ-004: req_valid  input  1  operation request valid.
- REQ-005: req_ready  output  1  issuer accepts a request this cycle.
- REQ-006: req_a  input  8  operand A.
- REQ-007: req_b  input  8  operand B.
- REQ-008: req_cmd  input  8  ALU command byte.
- REQ-009: ABCmd_o  output  8  shared operand/command bus to ALU8_Mult ABCmd_i.
- REQ-010: LoadA_o / LoadB_o / LoadCmd_o  output  1 each  load strobes to the ALU.
- REQ-011: ACC_i  input  8  ALU accumulator result.
- REQ-012: Done_i  input  1  ALU completion level.
- REQ-013: rsp_valid  output  1  result valid.
- REQ-014: rsp_ready  input  1  consumer accepts the result.
- REQ-015: rsp_data  output  8  captured ACC_i.
- REQ-016: rsp_err  output  1  timeout flag qualifying rsp_valid.

Function
- REQ-017: FSM states IDLE, LD_A, LD_B, LD_CMD, WAIT, RESP; exactly one state active at a time.
- REQ-018: IDLE: req_ready=1; req_valid&req_ready latch req_a/b/cmd into internal registers -> LD_A next cycle.
- REQ-019: LD_A: ABCmd_o=A, LoadA_o=1 for exactly one cycle -> LD_B.
- REQ-020: LD_B: ABCmd_o=B, LoadB_o=1 for one cycle -> LD_CMD.
- REQ-021: LD_CMD: ABCmd_o=cmd, LoadCmd_o=1 for one cycle -> WAIT; wait counter cleared.
- REQ-022: At most one Load*_o strobe asserted per cycle; outside LD_* states all strobes 0 and ABCmd_o=0.
- REQ-023: WAIT: Done_i is sampled from the first WAIT cycle; when Done_i=1, rsp_data<=ACC_i, rsp_err<=0 -> RESP.
- REQ-024: Done_i already high on WAIT entry (stale from prior op) is accepted as completion; no edge detection.
- REQ-025: RESP: rsp_valid=1, rsp_data/rsp_err held stable until rsp_ready=1; transfer -> IDLE next cycle.
- REQ-026: req_ready=0 in every state except IDLE; requests are not buffered.
- REQ-027: Minimum latency acceptance->rsp_valid = 4 cycles (Done_i high on first WAIT cycle); throughput 1 op per >=6 cycles.
- REQ-028: Done_i outside WAIT is ignored.

Reset
- REQ-029: reset=1 at a clk edge forces IDLE from any state, including mid-load or WAIT, abandoning the operation with no response.
- REQ-030: Reset values: req_ready=0 during reset cycle then 1, ABCmd_o=0, all Load*_o=0, rsp_valid=0, rsp_data=0, rsp_err=0, internal registers and counter 0.

Configuration
- REQ-031: Macro ALU8_TIMEOUT_EN defined: 16-bit wait counter increments each WAIT cycle with Done_i=0; on reaching TIMEOUT_CYCLES, rsp_data<=0, rsp_err<=1 -> RESP.
- REQ-032: Done_i=1 on the same cycle the counter reaches the limit gives completion priority (rsp_err=0).
- REQ-033: ALU8_TIMEOUT_EN undefined: no counter logic, WAIT persists until Done_i or reset, rsp_err tied 0.

Verification
- REQ-034: A=0x12,B=0x34,cmd=0x03, Done_i raised 3 cycles after LoadCmd_o, ACC_i=0x58 -> strobes LoadA/LoadB/LoadCmd in 3 consecutive cycles with ABCmd_o 0x12/0x34/0x03, rsp_valid with rsp_data=0x58, rsp_err=0.
- REQ-035: rsp_ready held 0 for 10 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0, new req_valid ignored; release -> IDLE, next request accepted.
- REQ-036: Done_i held 1 continuously -> rsp_valid exactly 4 cycles after acceptance, ACC_i captured on first WAIT cycle.
- REQ-037: reset asserted in LD_B and again in WAIT -> next cycle IDLE, all strobes 0, no rsp_valid produced.
- REQ-038: ALU8_TIMEOUT_EN, TIMEOUT_CYCLES=8, Done_i never asserted -> rsp_valid with rsp_err=1, rsp_data=0 after 8 WAIT cycles; without macro, no response after 1000 cycles.
- REQ-039: Back-to-back requests with rsp_ready=1 and A=0xFF,B=0x00,cmd=0x80 then A=0x01,B=0x02,cmd=0x00 -> two responses in order, no strobe overlap.

Source files
------------

// File: rtl/alu8_cmd_issuer_if.sv
// Request/response handshake bundle between a client and the ALU8 command issuer.
// The slave modport is the issuer side; the master modport is the client side.
interface alu8_cmd_issuer_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [7:0] req_cmd;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_cmd,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_err
  );

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_cmd,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
  );
endinterface

// File: rtl/alu8_cmd_issuer.sv
// Sequences one request into A/B/command loads on the shared ALU8 bus and returns ACC_i.
// Define ALU8_TIMEOUT_EN to bound the Done_i wait by TIMEOUT_CYCLES (error response).
module alu8_cmd_issuer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  alu8_cmd_issuer_if.slave bus,
  output logic [7:0]       ABCmd_o,
  output logic             LoadA_o,
  output logic             LoadB_o,
  output logic             LoadCmd_o,
  input  logic [7:0]       ACC_i,
  input  logic             Done_i
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("alu8_cmd_issuer: TIMEOUT_CYCLES must be within 1..65535");
  end

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLdA   = 3'd1;
  localparam logic [2:0] StLdB   = 3'd2;
  localparam logic [2:0] StLdCmd = 3'd3;
  localparam logic [2:0] StWait  = 3'd4;
  localparam logic [2:0] StResp  = 3'd5;

  logic [2:0] state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] rsp_data_q, rsp_data_d;

`ifdef ALU8_TIMEOUT_EN
  localparam logic [16:0] TimeoutLimit = 17'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  logic        rsp_err_q, rsp_err_d;

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cmd_d      = cmd_q;
    rsp_data_d = rsp_data_q;
`ifdef ALU8_TIMEOUT_EN
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          cmd_d   = bus.req_cmd;
          state_d = StLdA;
        end
      end
      StLdA:   state_d = StLdB;
      StLdB:   state_d = StLdCmd;
      StLdCmd: begin
        state_d = StWait;
`ifdef ALU8_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        // A level already high on entry counts as completion; no edge detect.
        if (Done_i) begin
          rsp_data_d = ACC_i;
          state_d    = StResp;
`ifdef ALU8_TIMEOUT_EN
          rsp_err_d  = 1'b0;
        end else if (cnt_inc >= TimeoutLimit) begin
          cnt_d      = cnt_inc[15:0];
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
          state_d    = StResp;
        end else begin
          cnt_d      = cnt_inc[15:0];
`endif
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      cmd_q      <= 8'h00;
      rsp_data_q <= 8'h00;
`ifdef ALU8_TIMEOUT_EN
      cnt_q      <= 16'h0000;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cmd_q      <= cmd_d;
      rsp_data_q <= rsp_data_d;
`ifdef ALU8_TIMEOUT_EN
      cnt_q      <= cnt_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  // Bus and strobes decode straight from state so each load lasts exactly one cycle.
  always_comb begin
    ABCmd_o   = 8'h00;
    LoadA_o   = 1'b0;
    LoadB_o   = 1'b0;
    LoadCmd_o = 1'b0;
    case (state_q)
      StLdA: begin
        ABCmd_o = a_q;
        LoadA_o = 1'b1;
      end
      StLdB: begin
        ABCmd_o = b_q;
        LoadB_o = 1'b1;
      end
      StLdCmd: begin
        ABCmd_o   = cmd_q;
        LoadCmd_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state_q == StIdle) && !reset;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = rsp_data_q;
`ifdef ALU8_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu8_cmd_issuer.sv
// Directed self-checking bench for alu8_cmd_issuer; expectations are hand-computed.
module tb_alu8_cmd_issuer;

  logic       clk;
  logic       reset;
  logic [7:0] ABCmd_o;
  logic       LoadA_o;
  logic       LoadB_o;
  logic       LoadCmd_o;
  logic [7:0] ACC_i;
  logic       Done_i;

  int checks = 0;
  int errors = 0;

  alu8_cmd_issuer_if bus ();

  alu8_cmd_issuer #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ABCmd_o  (ABCmd_o),
    .LoadA_o  (LoadA_o),
    .LoadB_o  (LoadB_o),
    .LoadCmd_o(LoadCmd_o),
    .ACC_i    (ACC_i),
    .Done_i   (Done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] strobes();
    return {LoadA_o, LoadB_o, LoadCmd_o};
  endfunction

  task automatic set_req(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cmd   = c;
  endtask

  initial begin
    int seen;
    reset         = 1'b1;
    Done_i        = 1'b0;
    ACC_i         = 8'h00;
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 8'h00, 8'h00, 8'h00);

    // Reset state
    step();
    step();
    chk("rst_req_ready", 16'(bus.req_ready), 16'h0);
    chk("rst_abcmd", 16'(ABCmd_o), 16'h00);
    chk("rst_strobes", 16'(strobes()), 16'h0);
    chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
    chk("rst_rsp_data", 16'(bus.rsp_data), 16'h00);
    chk("rst_rsp_err", 16'(bus.rsp_err), 16'h0);
    reset = 1'b0;
    #1;
    chk("idle_req_ready", 16'(bus.req_ready), 16'h1);

    // Basic op: Done raised three cycles after the command load
    set_req(1'b1, 8'h12, 8'h34, 8'h03);
    step();
    set_req(1'b0, 8'h00, 8'h00, 8'h00);
    chk("b_lda_strobes", 16'(strobes()), 16'h4);
    chk("b_lda_bus", 16'(ABCmd_o), 16'h12);
    chk("b_lda_ready", 16'(bus.req_ready), 16'h0);
    step();
    chk("b_ldb_strobes", 16'(strobes()), 16'h2);
    chk("b_ldb_bus", 16'(ABCmd_o), 16'h34);
    step();
    chk("b_ldc_strobes", 16'(strobes()), 16'h1);
    chk("b_ldc_bus", 16'(ABCmd_o), 16'h03);
    step();
    chk("b_w1_strobes", 16'(strobes()), 16'h0);
    chk("b_w1_bus", 16'(ABCmd_o), 16'h00);
    step();
    step();
    chk("b_w3_valid", 16'(bus.rsp_valid), 16'h0);
    Done_i = 1'b1;
    ACC_i  = 8'h58;
    step();
    Done_i = 1'b0;
    chk("b_rsp_valid", 16'(bus.rsp_valid), 16'h1);
    chk("b_rsp_data", 16'(bus.rsp_data), 16'h58);
    chk("b_rsp_err", 16'(bus.rsp_err), 16'h0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("b_back_idle_valid", 16'(bus.rsp_valid), 16'h0);
    chk("b_back_idle_ready", 16'(bus.req_ready), 16'h1);

    // Done held high throughout: minimum latency, capture on first WAIT cycle
    Done_i = 1'b1;
    ACC_i  = 8'h77;
    set_req(1'b1, 8'h11, 8'h22, 8'h33);
    step();
    set_req(1'b0, 8'h00, 8'h00, 8'h00);
    step();
    step();
    step();
    chk("lat_wait_valid", 16'(bus.rsp_valid), 16'h0);
    ACC_i = 8'hA5;
    step();
    ACC_i = 8'h5A;
    chk("lat_rsp_valid", 16'(bus.rsp_valid), 16'h1);
    chk("lat_rsp_data", 16'(bus.rsp_data), 16'hA5);

    // Backpressure: response held, new requests ignored
    set_req(1'b1, 8'h21, 8'h22, 8'h23);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 16'(bus.rsp_valid), 16'h1);
      chk("bp_data", 16'(bus.rsp_data), 16'hA5);
      chk("bp_req_ready", 16'(bus.req_ready), 16'h0);
      chk("bp_strobes", 16'(strobes()), 16'h0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("bp_idle_ready", 16'(bus.req_ready), 16'h1);
    chk("bp_idle_strobes", 16'(strobes()), 16'h0);
    step();
    set_req(1'b0, 8'h00, 8'h00, 8'h00);
    chk("bp_next_lda", 16'(strobes()), 16'h4);
    chk("bp_next_bus", 16'(ABCmd_o), 16'h21);

    // Reset during LD_B
    step();
    chk("rl_ldb_strobes", 16'(strobes()), 16'h2);
    reset = 1'b1;
    step();
    chk("rl_strobes", 16'(strobes()), 16'h0);
    chk("rl_bus", 16'(ABCmd_o), 16'h00);
    reset = 1'b0;
    #1;
    chk("rl_idle_ready", 16'(bus.req_ready), 16'h1);
    chk("rl_no_valid", 16'(bus.rsp_valid), 16'h0);

    // Reset during WAIT, with Done arriving in the same cycle
    Done_i = 1'b0;
    set_req(1'b1, 8'h44, 8'h55, 8'h66);
    step();
    set_req(1'b0, 8'h00, 8'h00, 8'h00);
    step();
    step();
    step();
    chk("rw_wait_strobes", 16'(strobes()), 16'h0);
    chk("rw_wait_valid", 16'(bus.rsp_valid), 16'h0);
    reset  = 1'b1;
    Done_i = 1'b1;
    step();
    reset  = 1'b0;
    Done_i = 1'b0;
    #1;
    chk("rw_idle_ready", 16'(bus.req_ready), 16'h1);
    chk("rw_no_valid", 16'(bus.rsp_valid), 16'h0);
    step();
    step();
    chk("rw_still_no_valid", 16'(bus.rsp_valid), 16'h0);

    // Back-to-back requests with rsp_ready high
    bus.rsp_ready = 1'b1;
    Done_i        = 1'b1;
    ACC_i         = 8'h7F;
    set_req(1'b1, 8'hFF, 8'h00, 8'h80);
    step();
    set_req(1'b1, 8'h01, 8'h02, 8'h00);
    chk("bb1_lda", 16'(strobes()), 16'h4);
    chk("bb1_bus_a", 16'(ABCmd_o), 16'hFF);
    step();
    chk("bb1_ldb", 16'(strobes()), 16'h2);
    chk("bb1_bus_b", 16'(ABCmd_o), 16'h00);
    step();
    chk("bb1_ldc", 16'(strobes()), 16'h1);
    chk("bb1_bus_c", 16'(ABCmd_o), 16'h80);
    step();
    chk("bb1_wait", 16'(strobes()), 16'h0);
    step();
    chk("bb1_valid", 16'(bus.rsp_valid), 16'h1);
    chk("bb1_data", 16'(bus.rsp_data), 16'h7F);
    ACC_i = 8'h03;
    step();
    chk("bb_idle_ready", 16'(bus.req_ready), 16'h1);
    chk("bb_idle_strobes", 16'(strobes()), 16'h0);
    step();
    set_req(1'b0, 8'h00, 8'h00, 8'h00);
    chk("bb2_lda", 16'(strobes()), 16'h4);
    chk("bb2_bus_a", 16'(ABCmd_o), 16'h01);
    step();
    chk("bb2_ldb", 16'(strobes()), 16'h2);
    chk("bb2_bus_b", 16'(ABCmd_o), 16'h02);
    step();
    chk("bb2_ldc", 16'(strobes()), 16'h1);
    chk("bb2_bus_c", 16'(ABCmd_o), 16'h00);
    step();
    step();
    chk("bb2_valid", 16'(bus.rsp_valid), 16'h1);
    chk("bb2_data", 16'(bus.rsp_data), 16'h03);
    chk("bb2_err", 16'(bus.rsp_err), 16'h0);
    step();
    bus.rsp_ready = 1'b0;
    Done_i        = 1'b0;

    // Done never arrives
    set_req(1'b1, 8'h0A, 8'h0B, 8'h0C);
    step();
    set_req(1'b0, 8'h00, 8'h00, 8'h00);
    step();
    step();
    step();
`ifdef ALU8_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      step();
    end
    chk("to_before_limit", 16'(bus.rsp_valid), 16'h0);
    step();
    chk("to_valid", 16'(bus.rsp_valid), 16'h1);
    chk("to_err", 16'(bus.rsp_err), 16'h1);
    chk("to_data", 16'(bus.rsp_data), 16'h00);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("to_idle_ready", 16'(bus.req_ready), 16'h1);
`else
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (bus.rsp_valid) seen++;
    end
    chk("nto_no_rsp", 16'(seen), 16'h0);
    chk("nto_req_ready", 16'(bus.req_ready), 16'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("nto_reset_idle", 16'(bus.req_ready), 16'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
